// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// address tracking, branch-squash of in-flight words and a prefetch FIFO.

module if_fetch_unit_chk #(
  parameter int OW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          imem_rvalid,
  input logic [OW-1:0] outst
);

  // A response with nothing outstanding is a memory protocol violation.
  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (outst != {OW{1'b0}}));

endmodule

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int AW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] aq_rd_q, aq_rd_d;
  logic [AW-1:0] aq_wr_q, aq_wr_d;
  logic [31:0]   fifo_pc_q    [FIFO_DEPTH];
  logic [31:0]   fifo_instr_q [FIFO_DEPTH];
  logic [31:0]   aq_q         [MAX_OUTST];

  logic [31:0] in_use_s;
  logic        credit_s;
  logic        req_fire_s;
  logic        resp_fire_s;
  logic        keep_s;
  logic        pop_s;
  logic [31:0] resp_pc_s;

  // Dropped in-flight words still occupy a credit until their response lands.
  assign in_use_s    = 32'(outst_q) + 32'(cnt_q);
  assign credit_s    = (in_use_s < 32'(FIFO_DEPTH)) && (32'(outst_q) < 32'(MAX_OUTST))
                       && !branch_taken;
  assign imem_req    = rst && credit_s;
  assign imem_addr   = fetch_pc_q;
  assign req_fire_s  = imem_req && imem_gnt;
  assign resp_fire_s = imem_rvalid && (outst_q != {OW{1'b0}});
  assign keep_s      = resp_fire_s && (drop_q == {OW{1'b0}}) && !branch_taken;
  assign pop_s       = (cnt_q != {CW{1'b0}}) && !freeze && !branch_taken;
  assign resp_pc_s   = aq_q[aq_rd_q] + 32'd4;

  assign if_valid = (cnt_q != {CW{1'b0}});
  assign if_pc    = if_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0000_0000;
  assign if_instr = if_valid ? fifo_instr_q[rd_ptr_q] : 32'h0000_0000;

  // Next-state for PC, credit counters and queue pointers.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    aq_rd_d    = aq_rd_q;
    aq_wr_d    = aq_wr_q;

    if (branch_taken) begin
      fetch_pc_d = branch_addr;
    end else if (req_fire_s) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    case ({req_fire_s, resp_fire_s})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    // On redirect every word still in flight after this cycle is squashed.
    if (branch_taken) begin
      drop_d = resp_fire_s ? (outst_q - OW'(1)) : outst_q;
    end else if (resp_fire_s && (drop_q != {OW{1'b0}})) begin
      drop_d = drop_q - OW'(1);
    end else begin
      drop_d = drop_q;
    end

    if (branch_taken) begin
      cnt_d    = {CW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      wr_ptr_d = {PW{1'b0}};
    end else begin
      case ({keep_s, pop_s})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
      wr_ptr_d = keep_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    end

    if (req_fire_s) begin
      aq_wr_d = (aq_wr_q == AW'(MAX_OUTST - 1)) ? {AW{1'b0}} : (aq_wr_q + AW'(1));
    end else begin
      aq_wr_d = aq_wr_q;
    end
    if (resp_fire_s) begin
      aq_rd_d = (aq_rd_q == AW'(MAX_OUTST - 1)) ? {AW{1'b0}} : (aq_rd_q + AW'(1));
    end else begin
      aq_rd_d = aq_rd_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= {OW{1'b0}};
      drop_q     <= {OW{1'b0}};
      cnt_q      <= {CW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      aq_rd_q    <= {AW{1'b0}};
      aq_wr_q    <= {AW{1'b0}};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      aq_rd_q    <= aq_rd_d;
      aq_wr_q    <= aq_wr_d;
    end
  end

  // Prefetch FIFO storage; head becomes visible the cycle after the response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]    <= 32'h0000_0000;
        fifo_instr_q[i] <= 32'h0000_0000;
      end
    end else if (keep_s) begin
      fifo_pc_q[wr_ptr_q]    <= resp_pc_s;
      fifo_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // Request-address queue pairing each in-order response with its address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_OUTST; i++) begin
        aq_q[i] <= 32'h0000_0000;
      end
    end else if (req_fire_s) begin
      aq_q[aq_wr_q] <= fetch_pc_q;
    end
  end

  if_fetch_unit_chk #(.OW(OW)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .imem_rvalid (imem_rvalid),
    .outst       (outst_q)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: randomized freeze/branch/grant/latency traffic
// checked every cycle against a queue-based reference model.

module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;
  localparam int          MAX_OUTST  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  typedef struct { logic [31:0] addr; bit stale; } fly_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] addr; int ready; } mreq_t;

  fly_t        m_fly[$];
  ent_t        m_fifo[$];
  mreq_t       mem_q[$];
  logic [31:0] m_pc;
  int          cyc;
  int          n_chk;
  int          n_pass;

  if_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MAX_OUTST  (MAX_OUTST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic check_outputs(input bit exp_req);
    check_eq("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("if_valid", {31'd0, if_valid}, (m_fifo.size() > 0) ? 32'd1 : 32'd0);
    check_eq("if_pc", if_pc, (m_fifo.size() > 0) ? m_fifo[0].pc : 32'h0);
    check_eq("if_instr", if_instr, (m_fifo.size() > 0) ? m_fifo[0].instr : 32'h0);
  endtask

  // One clock: drive inputs, compare against the model, advance the model.
  task automatic run_cycle(input bit fz, input bit br, input logic [31:0] ba,
                           input bit g, input int lat);
    bit   exp_req;
    bit   keep;
    fly_t f;
    @(negedge clk);
    freeze       = fz;
    branch_taken = br;
    branch_addr  = ba;
    imem_gnt     = g;
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_of(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
    #1;
    exp_req = (m_fly.size() + m_fifo.size() < FIFO_DEPTH) && (m_fly.size() < MAX_OUTST) && !br;
    check_outputs(exp_req);

    keep = 1'b0;
    if (imem_rvalid) begin
      f = m_fly.pop_front();
      void'(mem_q.pop_front());
      keep = !f.stale && !br;
    end
    if (!br && !fz && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (keep) m_fifo.push_back('{pc: f.addr + 32'd4, instr: imem_rdata});
    if (br) begin
      m_fifo.delete();
      foreach (m_fly[i]) m_fly[i].stale = 1'b1;
      m_pc = ba;
    end else if (exp_req && g) begin
      m_fly.push_back('{addr: m_pc, stale: 1'b0});
      mem_q.push_back('{addr: m_pc, ready: cyc + lat});
      m_pc = m_pc + 32'd4;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    #1;
    check_eq("rst_req", {31'd0, imem_req}, 32'd0);
    check_eq("rst_addr", imem_addr, RESET_PC);
    check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_pc", if_pc, 32'h0);
    check_eq("rst_instr", if_instr, 32'h0);
    m_fly.delete();
    m_fifo.delete();
    mem_q.delete();
    m_pc = RESET_PC;
    @(negedge clk);
    rst = 1'b1;
    cyc++;
  endtask

  // Fill the pipe until two requests are in flight (bounded).
  task automatic fill_two();
    for (int i = 0; i < 12 && m_fly.size() < 2; i++) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 4);
    check_eq("two_inflight", m_fly.size(), 32'd2);
  endtask

  // Wait for the first valid head after a redirect and check its address.
  task automatic expect_head(input string tag, input logic [31:0] pc_exp);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1);
      if (if_valid) seen = 1'b1;
    end
    check_eq(tag, seen ? if_pc : 32'hDEAD_BEEF, pc_exp);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    cyc = 0;
    rst = 1'b0;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_addr = 32'h0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    m_pc = RESET_PC;
    do_reset();

    for (int i = 0; i < 20; i++) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);
    for (int i = 0; i < 5; i++)  run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1);
    check_eq("frozen_buffered", {31'd0, if_valid}, 32'd1);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 2);

    fill_two();
    run_cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1);
    expect_head("branch_head", 32'h0000_0104);

    for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1);
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);

    run_cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1);
    expect_head("wrap_head", 32'h0000_0000);
    for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);

    run_cycle(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1);
    run_cycle(1'b0, 1'b1, 32'h0000_0300, 1'b1, 1);
    expect_head("b2b_head", 32'h0000_0304);

    fill_two();
    do_reset();
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0,
                $urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
